// File: rtl/sha_nonce_scheduler_if.sv
// rtl/sha_nonce_scheduler_if.sv - shared memory port and SHA core control bundle
//
// Groups the signals exchanged between the nonce scheduler and its
// surroundings (memory and SHA-256 core).
//   master (scheduler): drives mem_we/mem_addr/mem_write_data, core_reset_n,
//                       core_start; samples mem_read_data, core_done and the
//                       core's memory request core_mem_*.
//   slave  (memory + core side): the mirror image.
interface sha_nonce_scheduler_if;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        core_reset_n;
    logic        core_start;
    logic        core_done;
    logic        core_mem_we;
    logic [15:0] core_mem_addr;
    logic [31:0] core_mem_write_data;

    modport master (
        output mem_we, mem_addr, mem_write_data, core_reset_n, core_start,
        input  mem_read_data, core_done, core_mem_we, core_mem_addr, core_mem_write_data
    );

    modport slave (
        input  mem_we, mem_addr, mem_write_data, core_reset_n, core_start,
        output mem_read_data, core_done, core_mem_we, core_mem_addr, core_mem_write_data
    );
endinterface

// File: rtl/sha_nonce_scheduler.sv
// rtl/sha_nonce_scheduler.sv - nonce search sequencer for a single SHA-256 core
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start                   begin a search (only honoured in IDLE)
//   message_addr/output_addr message and digest base word addresses
//   nonce_start/nonce_end   inclusive nonce range, may wrap through zero
//   target                  success when hash word < target (unsigned)
//   busy/done/found/timeout search status
//   nonce_out               current (or winning) nonce
//   hash_word_out           last hash word read back
//   attempts                nonces checked in this search (saturating)
//   bus                     memory port and core control (master side)
module sha_nonce_scheduler #(
    parameter logic [15:0] NONCE_OFFSET = 16'd19,
    parameter logic [15:0] HASH_WORD    = 16'd0,
    parameter logic [15:0] CORE_TIMEOUT = 16'd1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_end,
    input  logic [31:0] target,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        timeout,
    output logic [31:0] nonce_out,
    output logic [31:0] hash_word_out,
    output logic [31:0] attempts,
    sha_nonce_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_NONCE,
        S_CORE_RST,
        S_CORE_GO,
        S_RUN_CORE,
        S_RD_WAIT,
        S_CHECK
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic        timeout_q, timeout_d;
    logic        core_start_q, core_start_d;
    logic        core_reset_n_q, core_reset_n_d;
    logic        wr_we_q, wr_we_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] nonce_q, nonce_d;
    logic [31:0] hash_q, hash_d;
    logic [31:0] attempts_q, attempts_d;
    logic [15:0] wdog_q, wdog_d;

    logic [31:0] nonce_next;
    assign nonce_next = nonce_q + 32'd1;

    always_comb begin
        state_d        = state_q;
        done_d         = done_q;
        found_d        = found_q;
        timeout_d      = timeout_q;
        core_start_d   = core_start_q;
        core_reset_n_d = core_reset_n_q;
        wr_we_d        = wr_we_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        nonce_d        = nonce_q;
        hash_d         = hash_q;
        attempts_d     = attempts_q;
        wdog_d         = wdog_q;

        case (state_q)
            S_IDLE: begin
                // Releases the core from its power-on reset on the first idle cycle.
                core_reset_n_d = 1'b1;
                if (start) begin
                    done_d     = 1'b0;
                    found_d    = 1'b0;
                    timeout_d  = 1'b0;
                    attempts_d = 32'd0;
                    nonce_d    = nonce_start;
                    wr_addr_d  = message_addr + NONCE_OFFSET;
                    wr_data_d  = nonce_start;
                    wr_we_d    = 1'b1;
                    state_d    = S_WR_NONCE;
                end
            end
            S_WR_NONCE: begin
                wr_we_d        = 1'b0;
                core_reset_n_d = 1'b0;
                state_d        = S_CORE_RST;
            end
            S_CORE_RST: begin
                core_reset_n_d = 1'b1;
                core_start_d   = 1'b1;
                wdog_d         = 16'd0;
                state_d        = S_CORE_GO;
            end
            S_CORE_GO: begin
                state_d = S_RUN_CORE;
            end
            S_RUN_CORE: begin
                wdog_d = wdog_q + 16'd1;
                if (bus.core_done) begin
                    core_start_d = 1'b0;
                    wr_addr_d    = output_addr + HASH_WORD;
                    state_d      = S_RD_WAIT;
                end else if (wdog_q == CORE_TIMEOUT) begin
                    done_d       = 1'b1;
                    timeout_d    = 1'b1;
                    found_d      = 1'b0;
                    core_start_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                // Address is clocked into the memory at the end of this cycle.
                state_d = S_CHECK;
            end
            S_CHECK: begin
                hash_d     = bus.mem_read_data;
                attempts_d = (attempts_q == 32'hFFFF_FFFF) ? attempts_q : attempts_q + 32'd1;
                if (bus.mem_read_data < target) begin
                    found_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (nonce_q == nonce_end) begin
                    found_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    nonce_d   = nonce_next;
                    wr_addr_d = message_addr + NONCE_OFFSET;
                    wr_data_d = nonce_next;
                    wr_we_d   = 1'b1;
                    state_d   = S_WR_NONCE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            found_q        <= 1'b0;
            timeout_q      <= 1'b0;
            core_start_q   <= 1'b0;
            core_reset_n_q <= 1'b0;
            wr_we_q        <= 1'b0;
            wr_addr_q      <= 16'd0;
            wr_data_q      <= 32'd0;
            nonce_q        <= 32'd0;
            hash_q         <= 32'd0;
            attempts_q     <= 32'd0;
            wdog_q         <= 16'd0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            found_q        <= found_d;
            timeout_q      <= timeout_d;
            core_start_q   <= core_start_d;
            core_reset_n_q <= core_reset_n_d;
            wr_we_q        <= wr_we_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            nonce_q        <= nonce_d;
            hash_q         <= hash_d;
            attempts_q     <= attempts_d;
            wdog_q         <= wdog_d;
        end
    end

    // The core owns the memory port only while it is running.
    always_comb begin
        if (state_q == S_RUN_CORE) begin
            bus.mem_we         = bus.core_mem_we;
            bus.mem_addr       = bus.core_mem_addr;
            bus.mem_write_data = bus.core_mem_write_data;
        end else begin
            bus.mem_we         = wr_we_q;
            bus.mem_addr       = wr_addr_q;
            bus.mem_write_data = wr_data_q;
        end
    end

    assign bus.core_reset_n = core_reset_n_q;
    assign bus.core_start   = core_start_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign found            = found_q;
    assign timeout          = timeout_q;
    assign nonce_out        = nonce_q;
    assign hash_word_out    = hash_q;
    assign attempts         = attempts_q;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// tb/tb_sha_nonce_scheduler.sv - scoreboard bench for sha_nonce_scheduler
module tb_sha_nonce_scheduler;

    localparam logic [15:0] MSG_ADDR   = 16'h0100;
    localparam logic [15:0] OUT_ADDR   = 16'h0200;
    localparam logic [15:0] NONCE_ADDR = 16'h0113;
    localparam logic [15:0] IDLE_ADDR  = 16'h5A5A;
    localparam int          CORE_LAT   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] nonce_start = 32'd0;
    logic [31:0] nonce_end = 32'd0;
    logic [31:0] target = 32'd0;
    logic        busy, done, found, timeout;
    logic [31:0] nonce_out, hash_word_out, attempts;

    sha_nonce_scheduler_if bus_if ();

    sha_nonce_scheduler #(
        .NONCE_OFFSET(16'd19),
        .HASH_WORD   (16'd0),
        .CORE_TIMEOUT(16'd20)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .message_addr (MSG_ADDR),
        .output_addr  (OUT_ADDR),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .target       (target),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .timeout      (timeout),
        .nonce_out    (nonce_out),
        .hash_word_out(hash_word_out),
        .attempts     (attempts),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Memory and core models
    logic [31:0] mem [0:65535];
    int          core_mode = 0;
    int          ccnt;

    function automatic logic [31:0] hash_of(input int mode, input logic [31:0] n);
        case (mode)
            0:       return 32'h0000_1234;
            1:       return n ^ 32'hA5A5_0000;
            3:       return (n == 32'd0) ? 32'h0000_0010 : 32'h8000_0000 + n;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_write_data;
        bus_if.mem_read_data <= mem[bus_if.mem_addr];
    end

    always @(posedge clk) begin
        if (!bus_if.core_reset_n) begin
            ccnt                       <= 0;
            bus_if.core_done           <= 1'b0;
            bus_if.core_mem_we         <= 1'b0;
            bus_if.core_mem_addr       <= IDLE_ADDR;
            bus_if.core_mem_write_data <= 32'd0;
        end else if (bus_if.core_start && !bus_if.core_done && core_mode != 2) begin
            ccnt <= ccnt + 1;
            if (ccnt == CORE_LAT) begin
                bus_if.core_mem_we         <= 1'b1;
                bus_if.core_mem_addr       <= OUT_ADDR;
                bus_if.core_mem_write_data <= hash_of(core_mode, mem[NONCE_ADDR]);
            end else if (ccnt == CORE_LAT + 1) begin
                bus_if.core_mem_we   <= 1'b0;
                bus_if.core_mem_addr <= IDLE_ADDR;
                bus_if.core_done     <= 1'b1;
            end
        end
    end

    // Scoreboards
    typedef struct {
        logic        found;
        logic        timeout;
        logic [31:0] nonce;
        logic [31:0] attempts;
        logic [31:0] hash;
        logic        chk_hash;
        int          cycles;
        int          pulses;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_wr_q[$];

    logic busy_prev = 1'b0, done_prev = 1'b0, crn_prev = 1'b0;
    int   cyc = 0;
    int   pulses = 0;

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] w;
        if (busy && !busy_prev) begin
            cyc = 0;
            pulses = 0;
        end else begin
            cyc++;
        end
        if (busy && crn_prev && !bus_if.core_reset_n) pulses++;

        if (reset_n && bus_if.mem_we && bus_if.mem_addr == NONCE_ADDR) begin
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_nonce_write", bus_if.mem_write_data, 32'hDEAD_BEEF);
            end else begin
                w = exp_wr_q.pop_front();
                chk("nonce_write", bus_if.mem_write_data, w);
            end
        end

        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("found", {31'd0, found}, {31'd0, e.found});
                chk("timeout", {31'd0, timeout}, {31'd0, e.timeout});
                chk("nonce_out", nonce_out, e.nonce);
                chk("attempts", attempts, e.attempts);
                if (e.chk_hash) chk("hash_word_out", hash_word_out, e.hash);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("core_start_at_done", {31'd0, bus_if.core_start}, 32'd0);
                chk("start_to_done_cycles", cyc, e.cycles);
                chk("core_reset_pulses", pulses, e.pulses);
            end
        end
        busy_prev = busy;
        done_prev = done;
        crn_prev  = bus_if.core_reset_n;
    end

    // Stimulus helpers
    task automatic push_exp(input logic f, input logic t, input logic [31:0] n,
                            input logic [31:0] a, input logic [31:0] h, input logic ch,
                            input int cy, input int p);
        exp_t e;
        e.found = f; e.timeout = t; e.nonce = n; e.attempts = a;
        e.hash = h; e.chk_hash = ch; e.cycles = cy; e.pulses = p;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ns, input logic [31:0] ne,
                         input logic [31:0] tg, input int mode);
        @(negedge clk);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        core_mode   = mode;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk(nm, {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_core_start(input string nm);
        int n;
        n = 0;
        while (!bus_if.core_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.core_start) chk(nm, {31'd0, bus_if.core_start}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_core_reset_n", {31'd0, bus_if.core_reset_n}, 32'd0);
        chk("rst_core_start", {31'd0, bus_if.core_start}, 32'd0);
        chk("rst_mem_we", {31'd0, bus_if.mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, bus_if.mem_addr}, 32'd0);
        chk("rst_nonce_out", nonce_out, 32'd0);
        chk("rst_attempts", attempts, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_core_reset_n", {31'd0, bus_if.core_reset_n}, 32'd1);

        // Found on the first try, with mux check and an ignored start pulse
        exp_wr_q.push_back(32'd5);
        push_exp(1'b1, 1'b0, 32'd5, 32'd1, 32'h1234, 1'b1, 11, 1);
        issue(32'd5, 32'd5, 32'hFFFF_FFFF, 0);
        wait_core_start("core_start_wait");
        chk("mux_core_go_addr", {16'd0, bus_if.mem_addr}, {16'd0, NONCE_ADDR});
        @(negedge clk);
        chk("mux_run_addr", {16'd0, bus_if.mem_addr}, {16'd0, IDLE_ADDR});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_wait_first");
        chk("mem_nonce_word", mem[NONCE_ADDR], 32'd5);
        repeat (3) @(negedge clk);
        chk("no_restart_busy", {31'd0, busy}, 32'd0);
        chk("done_held", {31'd0, done}, 32'd1);

        // Exhausted range
        for (int i = 10; i <= 13; i++) exp_wr_q.push_back(i);
        push_exp(1'b0, 1'b0, 32'd13, 32'd4, 32'hA5A5_000D, 1'b1, 44, 4);
        issue(32'd10, 32'd13, 32'd0, 1);
        wait_done("done_wait_exhaust");

        // Wrap-around through zero
        exp_wr_q.push_back(32'hFFFF_FFFE);
        exp_wr_q.push_back(32'hFFFF_FFFF);
        exp_wr_q.push_back(32'd0);
        push_exp(1'b1, 1'b0, 32'd0, 32'd3, 32'h10, 1'b1, 33, 3);
        issue(32'hFFFF_FFFE, 32'd1, 32'h100, 3);
        wait_done("done_wait_wrap");

        // Core never finishes
        exp_wr_q.push_back(32'd100);
        push_exp(1'b0, 1'b1, 32'd100, 32'd0, 32'd0, 1'b0, 24, 1);
        issue(32'd100, 32'd200, 32'hFFFF_FFFF, 2);
        wait_done("done_wait_timeout");

        // Reset in the middle of RUN_CORE, then a normal search
        exp_wr_q.push_back(32'd7);
        issue(32'd7, 32'd7, 32'hFFFF_FFFF, 2);
        wait_core_start("core_start_wait_rst");
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_core_reset_n", {31'd0, bus_if.core_reset_n}, 32'd0);
        chk("midrst_mem_we", {31'd0, bus_if.mem_we}, 32'd0);
        @(negedge clk);

        exp_wr_q.push_back(32'd42);
        push_exp(1'b1, 1'b0, 32'd42, 32'd1, 32'h1234, 1'b1, 11, 1);
        issue(32'd42, 32'd50, 32'hFFFF_FFFF, 0);
        wait_done("done_wait_after_rst");

        repeat (2) @(negedge clk);
        chk("exp_results_drained", exp_q.size(), 32'd0);
        chk("exp_writes_drained", exp_wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
